// File: rtl/led_display_pkg.sv
// Shared types, defaults and helpers for the HUB75 LED matrix PHY.
package led_display_pkg;

  localparam int unsigned DEF_SYS_CLK_FREQ   = 100_000_000;
  localparam int unsigned DEF_NUM_ROW_PIXELS = 32;
  localparam int unsigned DEF_NUM_COL_PIXELS = 64;
  localparam int unsigned DEF_BCLK_FREQ      = 25_000_000;

  typedef struct packed {
    logic r;
    logic g;
    logic b;
  } rgb_t;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    BLANK,
    LATCH
  } phy_state_t;

  // System cycles per bclk half-period, never below one.
  function automatic int unsigned calc_half_div(input int unsigned sys_hz,
                                                input int unsigned bclk_hz);
    int unsigned d;
    d = sys_hz / (2 * bclk_hz);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/led_display_driver_phy_bclk_gen.sv
// Bit-period counter: registered panel shift clock plus period start/end strobes.
module led_display_bclk_gen #(
  parameter int unsigned HALF_DIV = 2
) (
  input  logic clk_i,
  input  logic n_reset_i,
  input  logic en_i,
  input  logic bclk_en_i,
  output logic bclk_o,
  output logic period_start_o,
  output logic period_end_o
);

  localparam int unsigned PERIOD = 2 * HALF_DIV;
  localparam int unsigned CNT_W  = $clog2(PERIOD);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bclk_q, bclk_d;

  // bclk is computed from the next count so the flop output lines up with the phase.
  always_comb begin
    period_start_o = en_i && (cnt_q == '0);
    period_end_o   = en_i && (cnt_q == CNT_W'(PERIOD - 1));
    cnt_d          = '0;
    if (en_i && !period_end_o) cnt_d = cnt_q + 1'b1;
    bclk_d = bclk_en_i && (cnt_d >= CNT_W'(HALF_DIV));
  end

  always_ff @(posedge clk_i) begin
    if (!n_reset_i) begin
      cnt_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o = bclk_q;

endmodule

// File: rtl/led_display_driver_phy.sv
// HUB75 1/16-scan PHY: shifts one row pair out on bclk, blanks, sets the address and latches.
module led_display_driver_phy
  import led_display_pkg::*;
#(
  parameter  int unsigned SYS_CLK_FREQ   = DEF_SYS_CLK_FREQ,
  parameter  int unsigned NUM_ROW_PIXELS = DEF_NUM_ROW_PIXELS,
  parameter  int unsigned NUM_COL_PIXELS = DEF_NUM_COL_PIXELS,
  parameter  int unsigned BCLK_FREQ      = DEF_BCLK_FREQ,
  localparam int unsigned ADDR_W         = $clog2(NUM_ROW_PIXELS / 2)
) (
  input  logic                          clk_in,
  input  logic                          n_reset_in,
  input  logic [3*NUM_COL_PIXELS-1:0]   upper_pixels_in,
  input  logic [3*NUM_COL_PIXELS-1:0]   lower_pixels_in,
  input  logic [ADDR_W-1:0]             row_addr_in,
  input  logic                          row_valid_in,
  output logic                          row_ready_out,
  output logic [2:0]                    rgb_top_out,
  output logic [2:0]                    rgb_bot_out,
  output logic                          bclk_out,
  output logic                          lat_out,
  output logic                          oe_n_out,
  output logic [ADDR_W-1:0]             addr_out
);

  localparam int unsigned HALF_DIV = calc_half_div(SYS_CLK_FREQ, BCLK_FREQ);
  localparam int unsigned PIX_W    = 3 * NUM_COL_PIXELS;
  localparam int unsigned COL_W    = (NUM_COL_PIXELS > 1) ? $clog2(NUM_COL_PIXELS) : 1;

  phy_state_t        state_q;
  logic [PIX_W-1:0]  upper_q, lower_q;
  logic [ADDR_W-1:0] addr_cap_q, addr_q;
  logic [COL_W-1:0]  col_q;
  rgb_t              rgb_top_q, rgb_bot_q;
  logic              lat_q, oe_n_q, ready_q;

  logic accept, last_col, shift_next, busy;
  logic period_start, period_end;

  always_comb begin
    accept     = (state_q == IDLE) && row_valid_in && ready_q;
    last_col   = (col_q == '0);
    busy       = (state_q != IDLE);
    shift_next = accept || ((state_q == SHIFT) && !(period_end && last_col));
  end

  led_display_bclk_gen #(
    .HALF_DIV(HALF_DIV)
  ) u_bclk_gen (
    .clk_i         (clk_in),
    .n_reset_i     (n_reset_in),
    .en_i          (busy),
    .bclk_en_i     (shift_next),
    .bclk_o        (bclk_out),
    .period_start_o(period_start),
    .period_end_o  (period_end)
  );

  // The pixel shift registers advance at period start so the next column sits
  // at the MSBs by the time the period ends and the output registers reload.
  always_ff @(posedge clk_in) begin
    if (!n_reset_in) begin
      state_q    <= IDLE;
      upper_q    <= '0;
      lower_q    <= '0;
      addr_cap_q <= '0;
      addr_q     <= '0;
      col_q      <= '0;
      rgb_top_q  <= '0;
      rgb_bot_q  <= '0;
      lat_q      <= 1'b0;
      oe_n_q     <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ready_q <= 1'b1;
          if (accept) begin
            ready_q    <= 1'b0;
            upper_q    <= upper_pixels_in;
            lower_q    <= lower_pixels_in;
            addr_cap_q <= row_addr_in;
            col_q      <= COL_W'(NUM_COL_PIXELS - 1);
            rgb_top_q  <= upper_pixels_in[PIX_W-1 -: 3];
            rgb_bot_q  <= lower_pixels_in[PIX_W-1 -: 3];
            state_q    <= SHIFT;
          end
        end
        SHIFT: begin
          if (period_start) begin
            upper_q <= upper_q << 3;
            lower_q <= lower_q << 3;
          end
          if (period_end) begin
            if (last_col) begin
              rgb_top_q <= '0;
              rgb_bot_q <= '0;
              oe_n_q    <= 1'b1;
              state_q   <= BLANK;
            end else begin
              col_q     <= col_q - 1'b1;
              rgb_top_q <= upper_q[PIX_W-1 -: 3];
              rgb_bot_q <= lower_q[PIX_W-1 -: 3];
            end
          end
        end
        BLANK: begin
          if (period_end) begin
            lat_q   <= 1'b1;
            addr_q  <= addr_cap_q;
            state_q <= LATCH;
          end
        end
        LATCH: begin
          if (period_end) begin
            lat_q   <= 1'b0;
            oe_n_q  <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign row_ready_out = ready_q;
  assign rgb_top_out   = rgb_top_q;
  assign rgb_bot_out   = rgb_bot_q;
  assign lat_out       = lat_q;
  assign oe_n_out      = oe_n_q;
  assign addr_out      = addr_q;

endmodule

// File: tb/tb_led_display_driver_phy.sv
// Randomized self-checking bench for led_display_driver_phy against a row-timeline model.
module tb_led_display_driver_phy;

  localparam int NC        = 64;
  localparam int HD        = 2;
  localparam int T         = 2 * HD;
  localparam int PW        = 3 * NC;
  localparam int SHIFT_END = NC * T;
  localparam int BLANK_END = SHIFT_END + T;
  localparam int LATCH_END = BLANK_END + T;
  localparam int ROW_LAT   = LATCH_END + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PW-1:0] up_in, lo_in;
  logic [3:0]    addr_in;
  logic          valid;
  logic          ready, bclk, lat, oe_n;
  logic [2:0]    rgb_top, rgb_bot;
  logic [3:0]    addr;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_display_driver_phy #(
    .SYS_CLK_FREQ  (100_000_000),
    .NUM_ROW_PIXELS(32),
    .NUM_COL_PIXELS(64),
    .BCLK_FREQ     (25_000_000)
  ) dut (
    .clk_in         (clk),
    .n_reset_in     (rst_n),
    .upper_pixels_in(up_in),
    .lower_pixels_in(lo_in),
    .row_addr_in    (addr_in),
    .row_valid_in   (valid),
    .row_ready_out  (ready),
    .rgb_top_out    (rgb_top),
    .rgb_bot_out    (rgb_bot),
    .bclk_out       (bclk),
    .lat_out        (lat),
    .oe_n_out       (oe_n),
    .addr_out       (addr)
  );

  // Reference model: position within the accepted row's timeline
  int            m_k;
  bit            m_ready, m_oe_n;
  logic [3:0]    m_disp, m_cap_addr;
  logic [PW-1:0] m_up, m_lo;
  bit            accepted, row_done, last_rst;

  int         cyc;
  int         rises, hi_run, since_rise, oe_hi;
  bit         lit, prev_bclk;
  logic [2:0] first_top;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [PW-1:0] rand_pix();
    logic [PW-1:0] v;
    for (int i = 0; i < PW; i += 32) v[i +: 32] = $urandom();
    return v;
  endfunction

  task automatic model_update();
    accepted = 0;
    row_done = 0;
    last_rst = rst_n;
    if (!rst_n) begin
      m_k = 0; m_ready = 0; m_oe_n = 1; m_disp = '0;
    end else if (m_k == 0) begin
      if (valid && m_ready) begin
        m_up = up_in; m_lo = lo_in; m_cap_addr = addr_in;
        m_k = 1; m_ready = 0; accepted = 1;
      end else begin
        m_ready = 1;
      end
    end else begin
      m_k++;
      if (m_k == SHIFT_END + 1) m_oe_n = 1;
      if (m_k == BLANK_END + 1) m_disp = m_cap_addr;
      if (m_k == ROW_LAT) begin
        m_k = 0; m_oe_n = 0; m_ready = 1; row_done = 1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [2:0] e_top, e_bot;
    logic       e_bclk, e_lat;
    int         col, ph;
    e_top = '0; e_bot = '0; e_bclk = 0;
    if (m_k >= 1 && m_k <= SHIFT_END) begin
      col    = NC - 1 - (m_k - 1) / T;
      ph     = (m_k - 1) % T;
      e_top  = m_up[3*col +: 3];
      e_bot  = m_lo[3*col +: 3];
      e_bclk = (ph >= HD);
    end
    e_lat = (m_k > BLANK_END);
    chk("rgb_top", rgb_top, e_top);
    chk("rgb_bot", rgb_bot, e_bot);
    chk("bclk", bclk, e_bclk);
    chk("lat", lat, e_lat);
    chk("oe_n", oe_n, m_oe_n);
    chk("addr", addr, m_disp);
    chk("row_ready", ready, m_ready);

    if (!last_rst) begin
      rises = 0; hi_run = 0; since_rise = 0; oe_hi = 0; lit = 0;
    end else begin
      if (accepted) begin rises = 0; oe_hi = 0; end
      since_rise++;
      if (bclk && !prev_bclk) begin
        rises++;
        if (rises == 1) first_top = rgb_top;
        else chk("bclk_period", since_rise, T);
        since_rise = 0;
      end
      if (bclk) hi_run++;
      else if (prev_bclk) begin
        chk("bclk_high", hi_run, HD);
        hi_run = 0;
      end
      if (m_k != 0 && oe_n) oe_hi++;
      if (row_done) begin
        chk("bclk_rises", rises, NC);
        if (lit) chk("oe_blank_len", oe_hi, 2 * T);
        lit = 1;
      end
    end
    prev_bclk = bclk;
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_update();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_accept();
    int n = 0;
    do begin
      tick();
      n++;
    end while (!accepted && n < 400);
    chk("accept_seen", accepted, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_k != 0 && n < 400) begin
      tick();
      n++;
    end
    chk("row_finished", ready, 1);
  endtask

  task automatic send_row();
    valid = 1;
    wait_accept();
    valid = 0;
    wait_idle();
  endtask

  initial begin
    int n;
    int last_acc;
    cyc = 0; m_k = 0; m_ready = 0; m_oe_n = 1; m_disp = '0;
    rises = 0; hi_run = 0; since_rise = 0; oe_hi = 0; lit = 0; prev_bclk = 0;
    first_top = '0;
    rst_n = 0; valid = 0; up_in = '0; lo_in = '0; addr_in = '0;

    repeat (10) tick();
    chk("reset_oe_n", oe_n, 1);
    chk("reset_ready", ready, 0);
    rst_n = 1;
    tick();
    chk("ready_after_release", ready, 1);

    // Single row: upper all red, lower all blue, address 5
    for (int c = 0; c < NC; c++) begin
      up_in[3*c +: 3] = 3'b100;
      lo_in[3*c +: 3] = 3'b001;
    end
    addr_in = 4'd5;
    valid = 1;
    wait_accept();
    valid = 0;
    n = 1;
    while (oe_n !== 1'b0 && n < 400) begin
      tick();
      n++;
    end
    chk("latency", n, ROW_LAT);
    chk("lit_addr", addr, 5);

    // Column order marker
    up_in = '0;
    up_in[PW-1 -: 3] = 3'b111;
    lo_in = rand_pix();
    addr_in = 4'd9;
    send_row();
    chk("first_rise_top", first_top, 3'b111);

    // Back-to-back rows 0..15 with valid held high
    valid = 1;
    last_acc = 0;
    for (int r = 0; r < 16; r++) begin
      addr_in = r[3:0];
      up_in = rand_pix();
      lo_in = rand_pix();
      wait_accept();
      if (r > 0) chk("row_period", cyc - last_acc, ROW_LAT);
      last_acc = cyc;
    end
    valid = 0;
    wait_idle();

    // Reset in the middle of SHIFT, then a clean row
    up_in = rand_pix();
    lo_in = rand_pix();
    addr_in = 4'd3;
    valid = 1;
    wait_accept();
    valid = 0;
    n = 0;
    while (rises < 20 && n < 200) begin
      tick();
      n++;
    end
    chk("rises_before_abort", rises, 20);
    rst_n = 0;
    tick();
    rst_n = 1;
    tick();
    up_in = rand_pix();
    up_in[PW-1 -: 3] = 3'b101;
    lo_in = rand_pix();
    addr_in = 4'd12;
    send_row();
    chk("first_rise_after_abort", first_top, 3'b101);

    // Random traffic with gaps; data churns while the driver is busy
    for (int c = 0; c < 3000; c++) begin
      valid = ($urandom_range(0, 3) == 0);
      up_in = rand_pix();
      lo_in = rand_pix();
      addr_in = 4'($urandom_range(0, 15));
      tick();
    end
    valid = 0;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/led_display_driver_phy.md
Name: led_display_driver_phy

Overview:
- Physical-layer driver for a HUB75-style 64x32 RGB LED matrix at 1/16 scan.
- Accepts one row-pair of 1-bit RGB pixel data (upper and lower half) per handshake.
- Shifts the pixels out serially on a divided bit clock, blanks the panel, updates the row address and latches.
- Sits between the pattern generator/frame buffer and the panel connector pins.

Parameters:
- SYS_CLK_FREQ, 100_000_000, system clock frequency (Hz).
- NUM_ROW_PIXELS, 32, panel rows; scanned as NUM_ROW_PIXELS/2 row pairs.
- NUM_COL_PIXELS, 64, panel columns (shift length per row).
- BCLK_FREQ, 25_000_000, target panel bit-clock frequency (Hz).
- Derived: HALF_DIV = max(1, SYS_CLK_FREQ/(2*BCLK_FREQ)) (floor); T = 2*HALF_DIV system cycles; ADDR_W = $clog2(NUM_ROW_PIXELS/2).

Ports:
- clk_in  in  1  system clock; all logic on its rising edge.
- n_reset_in  in  1  synchronous, active-low reset.
- upper_pixels_in  in  3*NUM_COL_PIXELS  upper-half row; column c = bits [3c+2:3c] = {R,G,B}.
- lower_pixels_in  in  3*NUM_COL_PIXELS  lower-half row, same packing.
- row_addr_in  in  ADDR_W  row-pair index for this data.
- row_valid_in  in  1  upstream data valid.
- row_ready_out  out  1  driver can accept a row.
- rgb_top_out  out  3  {R0,G0,B0} panel data.
- rgb_bot_out  out  3  {R1,G1,B1} panel data.
- bclk_out  out  1  panel shift clock.
- lat_out  out  1  panel latch, active high.
- oe_n_out  out  1  panel output enable, active low.
- addr_out  out  ADDR_W  panel row address {D,C,B,A}.

Behaviour:
- Reset values (applied at the clock edge where n_reset_in=0): rgb_*=0, bclk=0, lat=0, oe_n=1, addr=0, row_ready=0, state IDLE. Reset mid-row aborts immediately and discards captured data.
- State machine IDLE -> SHIFT -> BLANK -> LATCH -> IDLE. All outputs are registered.
- IDLE:
  - row_ready_out=1.
  - On a cycle with row_valid_in & row_ready_out, capture both pixel vectors and row_addr_in, then go to SHIFT on the next cycle.
  - row_valid_in while not ready is ignored; the data must be held by upstream.
- SHIFT:
  - row_ready=0; NUM_COL_PIXELS bit periods of T cycles each.
  - In each period, rgb_top/rgb_bot show the column's bits for the whole period; bclk=0 for the first HALF_DIV cycles and 1 for the last HALF_DIV.
  - Column order: NUM_COL_PIXELS-1 first, column 0 last.
  - oe_n is unchanged, so the previously latched row stays lit.
- BLANK: one period T; oe_n=1, bclk=0, rgb=0.
- LATCH:
  - One period T; addr_out = captured address from the first cycle of the state; lat=1 for all T cycles; oe_n stays 1.
  - On exit, lat=0 and oe_n=0 in the same cycle as the return to IDLE.
- Timing:
  - Accepted-row to panel-lit latency = 1 + (NUM_COL_PIXELS+2)*T cycles.
  - Defaults: T=4, so 265 cycles.
  - With row_valid_in held high, row period = 265 cycles.
- addr_out changes only while oe_n=1. bclk never toggles outside SHIFT. lat is never high during SHIFT.
- Each rising bclk edge falls mid-period, so data has HALF_DIV cycles of setup and hold.
- Before the first row is latched after reset, oe_n remains 1.

Decomposition:
- Package led_display_pkg:
  - Default constants SYS_CLK_FREQ, NUM_ROW_PIXELS, NUM_COL_PIXELS, BCLK_FREQ.
  - rgb_t (3-bit struct R,G,B).
  - phy_state_t enum {IDLE, SHIFT, BLANK, LATCH}.
  - Helper function for HALF_DIV.
- One sub-module, led_display_bclk_gen: a counter producing registered bclk, a period-start strobe and a period-end strobe, enabled only in SHIFT/BLANK/LATCH.

Test Plan:
- Reset: hold n_reset_in=0 for 10 cycles -> oe_n=1, lat=0, bclk=0, addr=0, rgb=0, row_ready=0; row_ready=1 one cycle after release.
- Single row, addr 5, upper = all red (R bits=1), lower = all blue:
  - exactly 64 bclk rising edges, each sampling rgb_top=3'b100 and rgb_bot=3'b001;
  - then lat high for 4 cycles, with addr_out=5 already when lat rises;
  - oe_n=0 265 cycles after the handshake.
- Column order: upper column 63={1,1,1}, all other columns 0 -> first bclk rise samples 3'b111; rises 2..64 sample 3'b000.
- Back-to-back: row_valid held high for rows 0..15 -> addr_out steps 0..15, one per 265 cycles; oe_n high for exactly 8 cycles per row; no bclk during BLANK/LATCH.
- Reset mid-SHIFT (after 20 bclk edges) -> next cycle all outputs at reset values; the following row starts cleanly from column 63.
- Clock frequency: over 64 shift periods, count 4 cycles per bclk period (bclk high exactly 2 cycles) -> effective 25 MHz.
